// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV result serializer: FSM states, word constants
// and the header-word builder.
package spmv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        W1,
        W2,
        W3,
        W4,
        TERM
    } ser_state_t;

    localparam int          WORDS_PER_ENTRY = 5;
    localparam logic [31:0] TERM_WORD       = 32'hFFFF_FFFF;
    localparam int          HDR_ZERO_BIT    = 31;

    // Header word: zero-row flag in the top bit, row address right-aligned below it.
    function automatic logic [31:0] hdr_word(input logic zeros, input logic [30:0] addr_pad);
        logic [31:0] w;
        w               = {1'b0, addr_pad};
        w[HDR_ZERO_BIT] = zeros;
        return w;
    endfunction

endpackage

// File: rtl/spmv_res_fifo.sv
// Synchronous result-entry FIFO. Exposes the head entry and the one behind it so the
// serializer can chain entries without a bubble; occupancy is tracked by an explicit count.
module spmv_res_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [WIDTH-1:0]         next_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count_reg == '0);
    assign full       = (count_reg == (PTR_W+1)'(DEPTH));
    assign do_pop     = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push    = push && (!full || do_pop);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    assign head_data  = mem[rd_ptr_reg];
    assign next_data  = mem[rd_ptr_inc];
    assign count      = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/spmv_result_serializer.sv
// Serializes SpMV result entries into 32-bit words with a pass terminator.
// Optional macro ZERO_SKIP_EN drops zero rows and counts them in zero_skips.
module spmv_result_serializer
    import spmv_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_zeros,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    input  logic              in_done,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              overflow,
    output logic [ADDR_W:0]   row_count,
    output logic [ADDR_W:0]   zero_skips,
    output logic              busy
);

    // Entry layout: {term, zeros, addr, op1, op2}
    localparam int EW    = 2 + ADDR_W + 2 * DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              done_prev_reg;
    logic              term_pend_reg;
    logic              stage_valid_reg;
    logic [EW-1:0]     stage_entry_reg;
    logic [EW-1:0]     data_entry;
    logic [DATA_W-1:0] op1_masked;
    logic [DATA_W-1:0] op2_masked;
    logic              done_rise;
    logic              term_want;
    logic              data_take;
    logic              skip_zero;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [EW-1:0]     head_entry;
    logic [EW-1:0]     next_entry;
    logic              entry_lost;

    ser_state_t        state_reg;
    logic [31:0]       out_data_reg;
    logic              out_valid_reg;
    logic              out_last_reg;
    logic              overflow_reg;
    logic [ADDR_W:0]   row_count_reg;
    logic              adv;
    logic              more;

`ifdef ZERO_SKIP_EN
    assign skip_zero = in_valid && in_zeros;
`else
    assign skip_zero = 1'b0;
`endif

    assign data_take  = in_valid && !skip_zero;
    assign done_rise  = in_done && !done_prev_reg;
    assign term_want  = done_rise || term_pend_reg;
    assign op1_masked = in_zeros ? '0 : in_op1;
    assign op2_masked = in_zeros ? '0 : in_op2;
    assign data_entry = {1'b0, in_zeros, in_addr, op1_masked, op2_masked};

    // Input stage; a terminator colliding with data is deferred to the next free cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_prev_reg   <= 1'b0;
            term_pend_reg   <= 1'b0;
            stage_valid_reg <= 1'b0;
            stage_entry_reg <= '0;
        end else begin
            done_prev_reg <= in_done;
            if (data_take) begin
                stage_valid_reg <= 1'b1;
                stage_entry_reg <= data_entry;
                term_pend_reg   <= term_want;
            end else if (term_want) begin
                stage_valid_reg <= 1'b1;
                stage_entry_reg <= {1'b1, {(EW-1){1'b0}}};
                term_pend_reg   <= 1'b0;
            end else begin
                stage_valid_reg <= 1'b0;
                term_pend_reg   <= 1'b0;
            end
        end
    end

    assign fifo_push  = stage_valid_reg;
    assign entry_lost = stage_valid_reg && fifo_full && !fifo_pop;

    spmv_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (stage_entry_reg),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .next_data (next_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_reg  <= 1'b0;
            row_count_reg <= '0;
        end else begin
            if (entry_lost) begin
                overflow_reg <= 1'b1;
            end else if (stage_valid_reg && !stage_entry_reg[EW-1]) begin
                row_count_reg <= row_count_reg + 1'b1;
            end
        end
    end

`ifdef ZERO_SKIP_EN
    logic [ADDR_W:0] zero_skips_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_skips_reg <= '0;
        end else if (skip_zero) begin
            zero_skips_reg <= zero_skips_reg + 1'b1;
        end
    end

    assign zero_skips = zero_skips_reg;
`else
    assign zero_skips = '0;
`endif

    function automatic logic [31:0] first_word(input logic [EW-1:0] e);
        if (e[EW-1]) begin
            return TERM_WORD;
        end
        return hdr_word(e[EW-2], 31'(e[EW-3 -: ADDR_W]));
    endfunction

    function automatic logic [31:0] op_word(input logic [EW-1:0] e, input logic second,
                                            input logic low);
        logic [63:0] op;
        op = second ? 64'(e[DATA_W-1:0]) : 64'(e[2*DATA_W-1:DATA_W]);
        return low ? op[31:0] : op[63:32];
    endfunction

    // The entry being serialized stays at the FIFO head until its last word is taken.
    assign adv      = out_valid_reg && out_ready;
    assign fifo_pop = adv && ((state_reg == W4) || (state_reg == TERM));
    assign more     = (fifo_count > CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_reg     <= head_entry[EW-1] ? TERM : HDR;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= head_entry[EW-1];
                        out_data_reg  <= first_word(head_entry);
                    end
                end
                HDR: if (adv) begin
                    state_reg    <= W1;
                    out_data_reg <= op_word(head_entry, 1'b0, 1'b0);
                end
                W1: if (adv) begin
                    state_reg    <= W2;
                    out_data_reg <= op_word(head_entry, 1'b0, 1'b1);
                end
                W2: if (adv) begin
                    state_reg    <= W3;
                    out_data_reg <= op_word(head_entry, 1'b1, 1'b0);
                end
                W3: if (adv) begin
                    state_reg    <= W4;
                    out_data_reg <= op_word(head_entry, 1'b1, 1'b1);
                end
                W4, TERM: begin
                    if (adv) begin
                        if (more) begin
                            state_reg    <= next_entry[EW-1] ? TERM : HDR;
                            out_last_reg <= next_entry[EW-1];
                            out_data_reg <= first_word(next_entry);
                        end else begin
                            state_reg     <= IDLE;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            out_data_reg  <= '0;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                    out_data_reg  <= '0;
                end
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign overflow  = overflow_reg;
    assign row_count = row_count_reg;
    assign busy      = !fifo_empty || (state_reg != IDLE);

endmodule
